// File: rtl/shake_squeeze_serializer.sv
// SHAKE256 squeeze stage: serializes 1088-bit rate blocks LSB first under valid/ready,
// requesting a fresh permutation whenever a block runs out before the job does.
module shake_squeeze_serializer #(
  parameter int RATE_BITS = 1088,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] out_len,
  input  logic [RATE_BITS-1:0] block_in,
  input  logic                 block_valid,
  output logic                 block_ready,
  output logic                 perm_request,
  output logic                 serial_out,
  output logic                 serial_valid,
  input  logic                 serial_ready,
  output logic                 serial_last,
  output logic                 done,
  output logic [2:0]           debug_sq_state,
  output logic [10:0]          debug_sq_bitidx
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, WAIT_BLOCK = 3'd1, SHIFT = 3'd2, REQ_PERM = 3'd3, DONE = 3'd4
  } state_t;

  localparam logic [10:0]          LAST_IDX = 11'(RATE_BITS - 1);
  localparam logic [LEN_WIDTH-1:0] ONE      = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] TWO      = LEN_WIDTH'(2);

  state_t               state;
  logic [RATE_BITS-1:0] buffer;
  logic [10:0]          bit_idx;
  logic [LEN_WIDTH-1:0] remaining;
  logic [10:0]          next_idx;

  assign next_idx        = bit_idx + 11'd1;
  assign debug_sq_state  = state;
  assign debug_sq_bitidx = bit_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      buffer       <= '0;
      bit_idx      <= '0;
      remaining    <= '0;
      block_ready  <= 1'b0;
      perm_request <= 1'b0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      serial_last  <= 1'b0;
      done         <= 1'b0;
    end else begin
      perm_request <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            remaining <= out_len;
            bit_idx   <= '0;
            if (out_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state       <= WAIT_BLOCK;
              done        <= 1'b0;
              block_ready <= 1'b1;
            end
          end
        end
        WAIT_BLOCK: begin
          if (block_valid && block_ready) begin
            buffer       <= block_in;
            bit_idx      <= '0;
            state        <= SHIFT;
            block_ready  <= 1'b0;
            serial_valid <= 1'b1;
            serial_out   <= block_in[0];
            serial_last  <= (remaining == ONE);
          end
        end
        SHIFT: begin
          // Output registers are preloaded with the next bit so nothing depends on serial_ready combinationally.
          if (serial_ready) begin
            remaining <= remaining - ONE;
            if (remaining == ONE) begin
              state        <= DONE;
              done         <= 1'b1;
              serial_valid <= 1'b0;
              serial_out   <= 1'b0;
              serial_last  <= 1'b0;
            end else if (bit_idx == LAST_IDX) begin
              state        <= REQ_PERM;
              perm_request <= 1'b1;
              serial_valid <= 1'b0;
              serial_out   <= 1'b0;
            end else begin
              bit_idx     <= next_idx;
              serial_out  <= buffer[next_idx];
              serial_last <= (remaining == TWO);
            end
          end
        end
        REQ_PERM: begin
          state       <= WAIT_BLOCK;
          bit_idx     <= '0;
          block_ready <= 1'b1;
        end
        default: begin
          state        <= IDLE;
          block_ready  <= 1'b0;
          serial_valid <= 1'b0;
          serial_out   <= 1'b0;
          serial_last  <= 1'b0;
          done         <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/shake_squeeze_serializer.md
Name: shake_squeeze_serializer

Overview:
- Squeeze-side output stage of the SHAKE256 core; the counterpart to the serial-input padder.
- Takes 1088-bit rate blocks from the Keccak permutation and emits them one bit per cycle, LSB first (bit 0 of the block first), under a valid/ready handshake.
- Emits exactly the requested number of output bits.
- When a block is exhausted and more bits are required, pulses a permutation request and waits for the next block.

Parameters:
- RATE_BITS, 1088, rate block width in bits (136 bytes).
- LEN_WIDTH, 16, width of the requested output length in bits.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin a squeeze job; sampled only in IDLE or DONE
- out_len  input  LEN_WIDTH  number of output bits; latched on accepted start
- block_in  input  RATE_BITS  rate portion of the Keccak state
- block_valid  input  1  block_in is valid
- block_ready  output  1  serializer accepts a block this cycle
- perm_request  output  1  one-cycle pulse requesting the next permutation
- serial_out  output  1  current output bit
- serial_valid  output  1  serial_out is valid
- serial_ready  input  1  downstream accepts the bit
- serial_last  output  1  current bit is the final bit of the job
- done  output  1  job complete; held until the next accepted start
- debug_sq_state  output  3  current FSM state
- debug_sq_bitidx  output  11  bit index within the current block

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; block buffer cleared; bit_idx = 0; remaining = 0.
  - All outputs 0.
  - Applies at any time, including mid-job: a partial job is abandoned with no done and no perm_request.
- States: IDLE = 0, WAIT_BLOCK = 1, SHIFT = 2, REQ_PERM = 3, DONE = 4. Unused encodings go to IDLE.
- IDLE / DONE:
  - start=1 latches remaining = out_len and clears done.
  - If out_len = 0: go to DONE, done = 1 next cycle, no bits emitted.
  - Otherwise go to WAIT_BLOCK.
  - In DONE, done stays 1 until a start is accepted.
- WAIT_BLOCK:
  - block_ready = 1 (registered; asserted the cycle after entry).
  - On block_valid & block_ready: capture block_in into the buffer, bit_idx = 0, go to SHIFT.
  - block_ready deasserts the cycle after capture.
- SHIFT:
  - serial_valid = 1; serial_out = buffer[bit_idx]; serial_last = 1 iff remaining = 1.
  - Outputs are driven only from registered state; no combinational path from serial_ready.
  - serial_ready = 0: all outputs stay stable.
  - serial_ready = 1 (bit accepted): remaining decrements.
    - If remaining was 1: go to DONE.
    - Else if bit_idx = RATE_BITS-1: go to REQ_PERM.
    - Else bit_idx increments.
  - Throughput: 1 bit/cycle while serial_ready is held high.
- REQ_PERM:
  - perm_request = 1 for exactly one cycle.
  - Then go to WAIT_BLOCK with bit_idx = 0.
  - serial_valid = 0 during REQ_PERM and WAIT_BLOCK.
- Latency:
  - start to block_ready: 1 cycle.
  - Block capture to first serial_valid: 1 cycle.
  - Exhaustion (last block bit accepted) to perm_request: 1 cycle.
- Bit order: block bit i is emitted i-th, matching the padder's bit-index ordering.
- Boundary conditions:
  - out_len = RATE_BITS: the last bit coincides with block exhaustion; go to DONE, no perm_request.
  - out_len = RATE_BITS+1: exactly one perm_request.
  - start while in WAIT_BLOCK, SHIFT or REQ_PERM: ignored.
  - block_valid outside WAIT_BLOCK: ignored, buffer unchanged.
- Arithmetic:
  - remaining is LEN_WIDTH bits; it never underflows because the decrement happens only when remaining ≥ 1.
  - bit_idx is 11 bits and never exceeds RATE_BITS-1.

Test Plan:
- out_len = 8, block_in[7:0] = 8'h1F, serial_ready held 1 → bits 1,1,1,1,1,0,0,0 on 8 consecutive cycles; serial_last on the 8th bit; done = 1 next cycle; perm_request never asserted.
- out_len = 1088, random block, serial_ready = 1 → 1088 bits matching block_in[0..1087]; serial_last on bit 1087; no perm_request; DONE reached.
- out_len = 1090, two distinct blocks → one perm_request pulse one cycle after bit 1087 is accepted; second block captured; its bits 0 and 1 emitted; serial_last on the second of them.
- out_len = 16, serial_ready toggling 1,0,0,1,… → serial_out, serial_valid and serial_last stable while ready = 0; exactly 16 accepted bits in order.
- out_len = 0 with start → done = 1 next cycle; serial_valid and block_ready never asserted; a new start with out_len = 4 re-arms and clears done.
- reset asserted mid-SHIFT at bit 500 → all outputs 0 immediately; state IDLE; after release, no serial_valid until a new start and block.
